// File: rtl/vram_arbiter.sv
// Single-port tile-RAM arbiter: display reads own the port in the active area,
// posted writes (FIFO) and blocking game reads are served only during blanking.
module vram_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_display,
    input  logic [ADDR_W-1:0]                disp_addr,
    output logic [DATA_W-1:0]                disp_data,
    output logic                             disp_valid,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             gr_req,
    input  logic [ADDR_W-1:0]                gr_addr,
    output logic                             gr_ack,
    output logic [DATA_W-1:0]                gr_data,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DISP = 2'd1;
    localparam logic [1:0] OWN_GR   = 2'd2;

    logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [1:0]        owner_reg;
    logic [1:0]        owner_next;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] wdata_hold_reg;
    logic              disp_valid_reg;
    logic [DATA_W-1:0] disp_data_reg;
    logic              gr_ack_reg;
    logic [DATA_W-1:0] gr_data_reg;

    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_empty = (level_reg == '0);
    assign wr_ready   = (level_reg != LVL_W'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    assign fifo_level = level_reg;
    assign disp_valid = disp_valid_reg;
    assign disp_data  = disp_data_reg;
    assign gr_ack     = gr_ack_reg;
    assign gr_data    = gr_data_reg;

    // Priority: display, then FIFO drain, then a single outstanding game read.
    always_comb begin
        owner_next = OWN_NONE;
        state_next = state_reg;
        mem_we     = 1'b0;
        mem_addr   = addr_hold_reg;
        mem_wdata  = wdata_hold_reg;
        pop        = 1'b0;

        case (state_reg)
            S_RD_WAIT: state_next = S_ACK;
            S_ACK:     state_next = S_IDLE;
            default:   state_next = state_reg;
        endcase

        if (in_display) begin
            mem_addr   = disp_addr;
            owner_next = OWN_DISP;
        end else if (!fifo_empty) begin
            mem_we    = 1'b1;
            mem_addr  = fifo_addr_mem[rd_ptr_reg];
            mem_wdata = fifo_data_mem[rd_ptr_reg];
            pop       = 1'b1;
        end else if (gr_req && state_reg == S_IDLE) begin
            mem_addr   = gr_addr;
            owner_next = OWN_GR;
            state_next = S_RD_WAIT;
        end

        // The RAM port must look quiet for the whole reset pulse, not just after an edge.
        if (rst) begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            pop       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= wr_addr;
            fifo_data_mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            state_reg      <= S_IDLE;
            owner_reg      <= OWN_NONE;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
            disp_valid_reg <= 1'b0;
            disp_data_reg  <= '0;
            gr_ack_reg     <= 1'b0;
            gr_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            addr_hold_reg  <= mem_addr;
            wdata_hold_reg <= mem_wdata;

            // owner_reg tags the access whose data mem_rdata carries this cycle.
            disp_valid_reg <= (owner_reg == OWN_DISP);
            gr_ack_reg     <= (owner_reg == OWN_GR);
            if (owner_reg == OWN_DISP) begin
                disp_data_reg <= mem_rdata;
            end
            if (owner_reg == OWN_GR) begin
                gr_data_reg <= mem_rdata;
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency tile RAM.
module tb_vram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_display;
    logic [3:0] disp_addr;
    logic [1:0] disp_data;
    logic       disp_valid;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [1:0] wr_data;
    logic       gr_req;
    logic [3:0] gr_addr;
    logic       gr_ack;
    logic [1:0] gr_data;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;
    logic [2:0] fifo_level;

    logic [1:0] ram [16];

    int checks = 0;
    int errors = 0;

    vram_arbiter #(.ADDR_W(4), .DATA_W(2), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_display (in_display),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .gr_req     (gr_req),
        .gr_addr    (gr_addr),
        .gr_ack     (gr_ack),
        .gr_data    (gr_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Tile RAM: cell 3 preloaded with X (01) while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                ram[i] <= 2'b00;
            end
            ram[3]    <= 2'b01;
            mem_rdata <= 2'b00;
        end else begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_display = 1'b0;
        disp_addr  = '0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        gr_req     = 1'b0;
        gr_addr    = '0;
        step;
        step;
        check("rst_level", 32'(fifo_level), 0);
        check("rst_disp_valid", 32'(disp_valid), 0);
        check("rst_disp_data", 32'(disp_data), 0);
        check("rst_gr_ack", 32'(gr_ack), 0);
        check("rst_gr_data", 32'(gr_data), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        rst = 1'b0;
        #1;
        check("rst_wr_ready", 32'(wr_ready), 1);

        // Display read of cell 3
        in_display = 1'b1;
        disp_addr  = 4'd3;
        #1;
        check("t1_mem_addr", 32'(mem_addr), 3);
        check("t1_mem_we", 32'(mem_we), 0);
        step;
        check("t1_valid_early", 32'(disp_valid), 0);
        step;
        check("t1_disp_valid", 32'(disp_valid), 1);
        check("t1_disp_data", 32'(disp_data), 1);

        // Two posted writes queued under display, drained in blanking
        wr_valid = 1'b1;
        wr_addr  = 4'd2;
        wr_data  = 2'b01;
        step;
        wr_addr  = 4'd5;
        wr_data  = 2'b10;
        step;
        wr_valid = 1'b0;
        #1;
        check("t2_level2", 32'(fifo_level), 2);
        check("t2_we_disp", 32'(mem_we), 0);
        in_display = 1'b0;
        #1;
        check("t2_we0", 32'(mem_we), 1);
        check("t2_addr0", 32'(mem_addr), 2);
        check("t2_wdata0", 32'(mem_wdata), 1);
        step;
        check("t2_we1", 32'(mem_we), 1);
        check("t2_addr1", 32'(mem_addr), 5);
        check("t2_wdata1", 32'(mem_wdata), 2);
        check("t2_level1", 32'(fifo_level), 1);
        step;
        check("t2_level0", 32'(fifo_level), 0);
        check("t2_we_idle", 32'(mem_we), 0);
        check("t2_addr_hold", 32'(mem_addr), 5);

        // Fill FIFO to depth, fifth write waits for first drain
        in_display = 1'b1;
        wr_valid   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_addr = 4'(8 + k);
            wr_data = (k % 2 == 1) ? 2'b10 : 2'b01;
            step;
        end
        wr_addr = 4'd12;
        wr_data = 2'b01;
        #1;
        check("t3_full_ready", 32'(wr_ready), 0);
        check("t3_full_level", 32'(fifo_level), 4);
        step;
        check("t3_hold_ready", 32'(wr_ready), 0);
        check("t3_hold_level", 32'(fifo_level), 4);
        in_display = 1'b0;
        #1;
        check("t3_drain0_we", 32'(mem_we), 1);
        check("t3_drain0_addr", 32'(mem_addr), 8);
        check("t3_no_bypass", 32'(wr_ready), 0);
        step;
        check("t3_level3", 32'(fifo_level), 3);
        check("t3_ready_again", 32'(wr_ready), 1);
        check("t3_drain1_addr", 32'(mem_addr), 9);
        step;
        wr_valid = 1'b0;
        check("t3_pushpop_level", 32'(fifo_level), 3);
        check("t3_drain2_addr", 32'(mem_addr), 10);
        step;
        check("t3_drain3_addr", 32'(mem_addr), 11);
        check("t3_drain3_data", 32'(mem_wdata), 2);
        step;
        check("t3_drain4_addr", 32'(mem_addr), 12);
        check("t3_drain4_data", 32'(mem_wdata), 1);
        step;
        check("t3_level_empty", 32'(fifo_level), 0);

        // Game read waits behind a queued write to the same cell
        wr_valid = 1'b1;
        wr_addr  = 4'd4;
        wr_data  = 2'b10;
        step;
        wr_valid = 1'b0;
        gr_req   = 1'b1;
        gr_addr  = 4'd4;
        #1;
        check("t4_drain_we", 32'(mem_we), 1);
        check("t4_drain_addr", 32'(mem_addr), 4);
        step;
        check("t4_issue_we", 32'(mem_we), 0);
        check("t4_issue_addr", 32'(mem_addr), 4);
        check("t4_issue_level", 32'(fifo_level), 0);
        step;
        check("t4_ack_early", 32'(gr_ack), 0);
        check("t4_wait_we", 32'(mem_we), 0);
        step;
        check("t4_ack", 32'(gr_ack), 1);
        check("t4_data", 32'(gr_data), 2);
        gr_req = 1'b0;
        step;
        check("t4_ack_once", 32'(gr_ack), 0);

        // Read in flight when display becomes active
        gr_req  = 1'b1;
        gr_addr = 4'd3;
        #1;
        check("t5_issue_addr", 32'(mem_addr), 3);
        check("t5_issue_we", 32'(mem_we), 0);
        step;
        in_display = 1'b1;
        disp_addr  = 4'd5;
        #1;
        check("t5_disp_addr", 32'(mem_addr), 5);
        step;
        check("t5_ack", 32'(gr_ack), 1);
        check("t5_data", 32'(gr_data), 1);
        check("t5_dv_early", 32'(disp_valid), 0);
        gr_req = 1'b0;
        step;
        check("t5_ack_once", 32'(gr_ack), 0);
        check("t5_disp_valid", 32'(disp_valid), 1);
        check("t5_disp_data", 32'(disp_data), 2);

        // Reset with a queued write and a read in flight
        in_display = 1'b0;
        gr_req     = 1'b1;
        gr_addr    = 4'd3;
        wr_valid   = 1'b1;
        wr_addr    = 4'd6;
        wr_data    = 2'b10;
        #1;
        check("t6_issue_addr", 32'(mem_addr), 3);
        step;
        in_display = 1'b1;
        wr_addr    = 4'd7;
        #1;
        check("t6_level_pre", 32'(fifo_level), 1);
        rst = 1'b1;
        #1;
        check("t6_level", 32'(fifo_level), 0);
        check("t6_gr_ack", 32'(gr_ack), 0);
        check("t6_mem_we", 32'(mem_we), 0);
        check("t6_mem_addr", 32'(mem_addr), 0);
        check("t6_mem_wdata", 32'(mem_wdata), 0);
        check("t6_disp_valid", 32'(disp_valid), 0);
        check("t6_wr_ready", 32'(wr_ready), 1);
        in_display = 1'b0;
        gr_req     = 1'b0;
        wr_valid   = 1'b0;
        step;
        step;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step;
            check("t6_post_we", 32'(mem_we), 0);
            check("t6_post_ack", 32'(gr_ack), 0);
        end
        check("t6_post_level", 32'(fifo_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
